// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard/forwarding unit
// Contents:
//   slot_t     packed in-flight slot record {valid, dst, we, is_load} at the default 5-bit width
//   XZR_ADDR   architectural zero register address (never matches)
//   fwd_none   select value meaning "read the register file"
package hazard_pkg;

    localparam int SLOT_ADDR_W = 5;
    localparam int XZR_ADDR    = 31;

    typedef struct packed {
        logic                   valid;
        logic [SLOT_ADDR_W-1:0] dst;
        logic                   we;
        logic                   is_load;
    } slot_t;

    function automatic int unsigned fwd_none();
        return 0;
    endfunction

endpackage

// File: rtl/reg_addr_match.sv
// rtl/reg_addr_match.sv - register address comparator with enable and zero-register exclusion
// Ports:
//   a    in  ADDR_W  source register address
//   b    in  ADDR_W  tracked destination register address
//   en   in  1       comparison qualified (source used, slot valid and writing)
//   hit  out 1       en AND a==b AND a is not the zero register
module reg_addr_match
    import hazard_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = XZR_ADDR
) (
    input  logic [ADDR_W-1:0] a,
    input  logic [ADDR_W-1:0] b,
    input  logic              en,
    output logic              hit
);

    assign hit = en && (a == b) && (a != ADDR_W'(ZERO_REG));

endmodule

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - in-flight destination tracker producing forwarding selects and load-use stall
// Ports:
//   clk          in  1                clock, rising edge
//   reset        in  1                asynchronous active-high reset
//   id_valid     in  1                decode holds a real instruction
//   id_src       in  NUM_SRC*ADDR_W   source addresses, source s at [s*ADDR_W +: ADDR_W]
//   id_src_used  in  NUM_SRC          source s is read
//   id_dst       in  ADDR_W           decode destination register
//   id_we        in  1                decode instruction writes id_dst
//   id_is_load   in  1                decode instruction is a load
//   flush        in  1                squash all tracked slots
//   fwd_sel      out NUM_SRC*SEL_W    0 = register file, k+1 = forward from slot k
//   stall        out 1                load-use hazard
//   stall_count  out 16               saturating stall counter (only with HAZ_STATS_EN)
// Optional feature macro: HAZ_STATS_EN
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter  int ADDR_W   = 5,
    parameter  int NUM_SRC  = 2,
    parameter  int DEPTH    = 3,
    parameter  int ZERO_REG = XZR_ADDR,
    localparam int SEL_W    = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic [NUM_SRC*ADDR_W-1:0] id_src,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic [ADDR_W-1:0]         id_dst,
    input  logic                      id_we,
    input  logic                      id_is_load,
    input  logic                      flush,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
    output logic                      stall
`ifdef HAZ_STATS_EN
    ,
    output logic [15:0]               stall_count
`endif
);

    // Same layout as hazard_pkg::slot_t, but sized by this instance's ADDR_W.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] dst;
        logic              we;
        logic              is_load;
    } slot_w_t;

    slot_w_t                    slot_q [DEPTH];
    logic [NUM_SRC*DEPTH-1:0]   hit;
    logic                       load_hit;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        for (genvar k = 0; k < DEPTH; k++) begin : g_slot
            reg_addr_match #(
                .ADDR_W   (ADDR_W),
                .ZERO_REG (ZERO_REG)
            ) u_match (
                .a   (id_src[s*ADDR_W +: ADDR_W]),
                .b   (slot_q[k].dst),
                .en  (id_src_used[s] & slot_q[k].valid & slot_q[k].we),
                .hit (hit[s*DEPTH + k])
            );
        end
    end

    // Scan oldest to youngest so the youngest producer overwrites the select.
    always_comb begin
        fwd_sel = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            fwd_sel[s*SEL_W +: SEL_W] = SEL_W'(fwd_none());
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (hit[s*DEPTH + k]) begin
                    fwd_sel[s*SEL_W +: SEL_W] = SEL_W'(k + 1);
                end
            end
        end
    end

    always_comb begin
        load_hit = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            load_hit = load_hit | hit[s*DEPTH];
        end
    end

    // Only a load still in slot 0 (EX) cannot forward in time; older loads forward normally.
    assign stall = id_valid & load_hit & slot_q[0].is_load;

    // The tracked pipeline always advances; stall only turns the new entry into a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                slot_q[k] <= '0;
            end
        end else if (flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                slot_q[k] <= slot_q[k-1];
            end
            if (id_valid && !stall) begin
                slot_q[0] <= '{valid: 1'b1, dst: id_dst, we: id_we, is_load: id_is_load};
            end else begin
                slot_q[0] <= '0;
            end
        end
    end

`ifdef HAZ_STATS_EN
    logic [15:0] stall_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count_q <= '0;
        end else if (stall && (stall_count_q != 16'hFFFF)) begin
            stall_count_q <= stall_count_q + 16'd1;
        end
    end

    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - self-checking bench for hazard_forward_unit
module tb_hazard_forward_unit;
    import hazard_pkg::*;

    localparam int ADDR_W  = 5;
    localparam int NUM_SRC = 2;
    localparam int DEPTH   = 3;
    localparam int SEL_W   = $clog2(DEPTH + 1);

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      id_valid;
    logic [NUM_SRC*ADDR_W-1:0] id_src;
    logic [NUM_SRC-1:0]        id_src_used;
    logic [ADDR_W-1:0]         id_dst;
    logic                      id_we;
    logic                      id_is_load;
    logic                      flush;
    logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
    logic                      stall;
`ifdef HAZ_STATS_EN
    logic [15:0]               stall_count;
`endif

    always #5 clk = ~clk;

    hazard_forward_unit dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_src      (id_src),
        .id_src_used (id_src_used),
        .id_dst      (id_dst),
        .id_we       (id_we),
        .id_is_load  (id_is_load),
        .flush       (flush),
        .fwd_sel     (fwd_sel),
        .stall       (stall)
`ifdef HAZ_STATS_EN
        ,
        .stall_count (stall_count)
`endif
    );

    // Reference: list of the last DEPTH issued entries, youngest first.
    slot_t model [DEPTH];
    int    vectors     = 0;
    int    miscompares = 0;
    int    model_stalls = 0;

    function automatic int src_of(int s);
        return int'(id_src[s*ADDR_W +: ADDR_W]);
    endfunction

    function automatic bit produces(int k, int reg_no);
        return model[k].valid && model[k].we && (int'(model[k].dst) == reg_no) && (reg_no != XZR_ADDR);
    endfunction

    function automatic int exp_sel(int s);
        if (!id_src_used[s]) return 0;
        for (int k = 0; k < DEPTH; k++) begin
            if (produces(k, src_of(s))) return k + 1;
        end
        return 0;
    endfunction

    function automatic bit exp_stall();
        if (!id_valid || !model[0].is_load) return 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (id_src_used[s] && produces(0, src_of(s))) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic clear_model();
        for (int k = 0; k < DEPTH; k++) model[k] = '0;
        model_stalls = 0;
    endtask

    task automatic check(input string tag);
        logic [SEL_W-1:0] obs;
        logic [SEL_W-1:0] expv;
        logic             exp_st;
        for (int s = 0; s < NUM_SRC; s++) begin
            obs  = fwd_sel[s*SEL_W +: SEL_W];
            expv = SEL_W'(exp_sel(s));
            vectors++;
            assert (obs === expv) else begin
                miscompares++;
                $error("FAIL %s fwd_sel[%0d] observed=%0d expected=%0d", tag, s, obs, expv);
            end
        end
        exp_st = exp_stall();
        vectors++;
        assert (stall === exp_st) else begin
            miscompares++;
            $error("FAIL %s stall observed=%0b expected=%0b", tag, stall, exp_st);
        end
    endtask

    // Drive one decode cycle (called just after a falling edge), check, then clock.
    task automatic step(input bit v, input int s0, input int s1, input bit [1:0] used,
                        input int dst, input bit we, input bit ld, input bit fl, input string tag);
        bit st;
        id_valid    = v;
        id_src      = {ADDR_W'(s1), ADDR_W'(s0)};
        id_src_used = used;
        id_dst      = ADDR_W'(dst);
        id_we       = we;
        id_is_load  = ld;
        flush       = fl;
        #1;
        check(tag);
        st = exp_stall();
        @(posedge clk);
        if (st) model_stalls++;
        if (fl) begin
            for (int k = 0; k < DEPTH; k++) model[k] = '0;
        end else begin
            for (int k = DEPTH - 1; k > 0; k--) model[k] = model[k-1];
            if (v && !st) model[0] = '{valid: 1'b1, dst: ADDR_W'(dst), we: we, is_load: ld};
            else          model[0] = '0;
        end
        @(negedge clk);
    endtask

    initial begin
        reset       = 1'b1;
        id_valid    = 1'b1;
        id_src      = {ADDR_W'(4), ADDR_W'(3)};
        id_src_used = 2'b11;
        id_dst      = '0;
        id_we       = 1'b0;
        id_is_load  = 1'b0;
        flush       = 1'b0;
        clear_model();
        #1;
        check("reset");
        @(negedge clk);
        reset = 1'b0;

        step(1, 3, 4, 2'b11, 0, 0, 0, 0, "empty_slots");

        step(1, 0, 0, 2'b00, 5, 1, 0, 0, "add_x5");
        step(1, 5, 0, 2'b01, 0, 0, 0, 0, "x5_slot0");
        step(1, 5, 0, 2'b01, 0, 0, 0, 0, "x5_slot1");
        step(1, 5, 0, 2'b01, 0, 0, 0, 0, "x5_slot2");
        step(1, 5, 0, 2'b01, 0, 0, 0, 0, "x5_gone");

        step(1, 0, 0, 2'b00, 7, 1, 1, 0, "ldr_x7");
        step(1, 0, 7, 2'b10, 0, 0, 0, 0, "load_use_stall");
        step(1, 0, 7, 2'b10, 0, 0, 0, 0, "load_use_fwd");

        step(1, 0, 0, 2'b00, 9, 1, 0, 0, "x9_old");
        step(1, 0, 0, 2'b00, 9, 1, 0, 0, "x9_young");
        step(1, 9, 9, 2'b11, 0, 0, 0, 0, "x9_both_youngest");
        step(1, 0, 0, 2'b00, 31, 1, 0, 0, "x31_write");
        step(1, 31, 31, 2'b11, 0, 0, 0, 0, "x31_nomatch");

        step(1, 0, 0, 2'b00, 2, 1, 1, 0, "ldr_x2");
        step(1, 2, 0, 2'b01, 0, 0, 0, 1, "flush_and_stall");
        step(1, 2, 0, 2'b01, 0, 0, 0, 0, "after_flush");

        step(1, 0, 0, 2'b00, 10, 1, 0, 0, "fill_x10");
        step(1, 0, 0, 2'b00, 11, 1, 1, 0, "fill_x11");
        step(1, 0, 0, 2'b00, 12, 1, 1, 0, "fill_x12");
        id_src      = {ADDR_W'(12), ADDR_W'(10)};
        id_src_used = 2'b11;
        id_valid    = 1'b1;
        #1;
        check("before_mid_reset");
        reset = 1'b1;
        #1;
        clear_model();
        check("mid_reset");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 400; i++) begin
            int r0, r1, rd;
            r0 = ($urandom_range(0, 9) == 0) ? 31 : int'($urandom_range(0, 7));
            r1 = ($urandom_range(0, 9) == 0) ? 31 : int'($urandom_range(0, 7));
            rd = ($urandom_range(0, 9) == 0) ? 31 : int'($urandom_range(0, 7));
            step(bit'($urandom_range(0, 7) != 0), r0, r1, 2'($urandom_range(0, 3)), rd,
                 bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 2) == 0),
                 bit'($urandom_range(0, 19) == 0), "random");
        end

`ifdef HAZ_STATS_EN
        vectors++;
        assert (stall_count === 16'(model_stalls)) else begin
            miscompares++;
            $error("FAIL stall_count observed=%0d expected=%0d", stall_count, model_stalls);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
